// File: rtl/bus_source_encoder_if.sv
// bus_source_encoder_if: request/select bundle between control logic and the bus source encoder.
// sel_onehot exists only when BUS_ENC_ONEHOT_OUT_EN is defined.
interface bus_source_encoder_if #(
  parameter int NUM_SRC = 32,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
);
  logic [NUM_SRC-1:0] out_req;
  logic err_clr;
  logic [SEL_W-1:0] sel;
  logic sel_valid;
  logic conflict;
  logic conflict_sticky;
  logic [CNT_W-1:0] conflict_count;
  logic fault;
`ifdef BUS_ENC_ONEHOT_OUT_EN
  logic [NUM_SRC-1:0] sel_onehot;
`endif
  modport master (
    output out_req, err_clr,
    input sel, sel_valid, conflict, conflict_sticky, conflict_count, fault
`ifdef BUS_ENC_ONEHOT_OUT_EN
    , sel_onehot
`endif
  );
  modport slave (
    input out_req, err_clr,
    output sel, sel_valid, conflict, conflict_sticky, conflict_count, fault
`ifdef BUS_ENC_ONEHOT_OUT_EN
    , sel_onehot
`endif
  );
endinterface

// File: rtl/bus_source_encoder.sv
// bus_source_encoder: one-hot out strobes to registered 32:1 bus select, with conflict tracking and fault lockout.
// Define BUS_ENC_ONEHOT_OUT_EN to add the registered sel_onehot output.
module bus_source_encoder #(
  parameter int NUM_SRC = 32,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8,
  parameter int FAULT_LIMIT = 4
) (
  input logic clk,
  input logic clr,
  bus_source_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, CONFL, FAULT} state_t;
  state_t state, state_d, eff;
  logic any, multi, hit, valid_d, conf_d, sticky_d;
  logic [SEL_W-1:0] low, sel_d;
  logic [CNT_W-1:0] cnt_base, cnt_d;
  logic [3:0] run, run_base, run_inc, run_d;
  always_comb begin
    low = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (bus.out_req[i]) low = SEL_W'(i);
  end
  assign any = |bus.out_req;
  assign multi = |(bus.out_req & (bus.out_req - NUM_SRC'(1)));
  // err_clr takes effect before this cycle's request is classified
  assign eff = (state == FAULT && bus.err_clr) ? IDLE : state;
  assign cnt_base = bus.err_clr ? '0 : bus.conflict_count;
  assign run_base = bus.err_clr ? 4'd0 : run;
  assign run_inc = run_base + 4'd1;
  always_comb begin
    state_d = eff == FAULT ? FAULT :
              !any ? IDLE :
              !multi ? DRIVE :
              run_inc == 4'(FAULT_LIMIT) ? FAULT : CONFL;
  end
  always_comb begin
    hit = eff != FAULT && multi;
    sel_d = (eff != FAULT && any) ? low : bus.sel;
    valid_d = any && state_d != FAULT;
    conf_d = hit;
    sticky_d = (bus.conflict_sticky && !bus.err_clr) || hit;
    cnt_d = !multi ? cnt_base : (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    run_d = hit ? run_inc : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      run <= '0;
      bus.sel <= '0;
      bus.sel_valid <= 1'b0;
      bus.conflict <= 1'b0;
      bus.conflict_sticky <= 1'b0;
      bus.conflict_count <= '0;
    end else begin
      state <= state_d;
      run <= run_d;
      bus.sel <= sel_d;
      bus.sel_valid <= valid_d;
      bus.conflict <= conf_d;
      bus.conflict_sticky <= sticky_d;
      bus.conflict_count <= cnt_d;
    end
  end
  assign bus.fault = state == FAULT;
`ifdef BUS_ENC_ONEHOT_OUT_EN
  always_ff @(posedge clk) bus.sel_onehot <= (clr || !valid_d) ? '0 : NUM_SRC'(1) << sel_d;
`endif
endmodule

// File: tb/tb_bus_source_encoder.sv
// tb_bus_source_encoder: directed plus random checks of two encoders (CNT_W 8 and 2) against a reference model.
module tb_bus_source_encoder;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  bus_source_encoder_if #(.CNT_W(8)) if_a ();
  bus_source_encoder_if #(.CNT_W(2)) if_b ();
  bus_source_encoder #(.CNT_W(8), .FAULT_LIMIT(LIMIT)) u_a (.clk(clk), .clr(clr), .bus(if_a));
  bus_source_encoder #(.CNT_W(2), .FAULT_LIMIT(LIMIT)) u_b (.clk(clk), .clr(clr), .bus(if_b));
  always #5 clk = ~clk;
  bit m_fault, m_valid, m_conf, m_sticky;
  int m_sel, m_run, m_cnt8, m_cnt2;
  function automatic int lowest(input logic [31:0] r);
    for (int i = 0; i < 32; i++) if (r[i]) return i;
    return 0;
  endfunction
  task automatic model(input logic [31:0] r, input bit e, input bit c);
    int n;
    n = $countones(r);
    if (c) begin
      {m_fault, m_valid, m_conf, m_sticky} = 4'b0;
      m_sel = 0; m_run = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    if (e) begin
      m_fault = 0; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0; m_run = 0;
    end
    m_conf = 0;
    if (m_fault) begin
      m_valid = 0;
      if (n > 1) begin
        m_cnt8 = m_cnt8 < 255 ? m_cnt8 + 1 : 255;
        m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
      end
    end else if (n == 0) begin
      m_valid = 0; m_run = 0;
    end else if (n == 1) begin
      m_sel = lowest(r); m_valid = 1; m_run = 0;
    end else begin
      m_sel = lowest(r); m_conf = 1; m_sticky = 1; m_run++;
      m_cnt8 = m_cnt8 < 255 ? m_cnt8 + 1 : 255;
      m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
      m_fault = m_run == LIMIT;
      m_valid = !m_fault;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [31:0] oh;
    oh = m_valid ? 32'd1 << m_sel : 32'd0;
    chk("sel_a", 64'(if_a.sel), 64'(m_sel));
    chk("valid_a", 64'(if_a.sel_valid), 64'(m_valid));
    chk("conflict_a", 64'(if_a.conflict), 64'(m_conf));
    chk("sticky_a", 64'(if_a.conflict_sticky), 64'(m_sticky));
    chk("count_a", 64'(if_a.conflict_count), 64'(m_cnt8));
    chk("fault_a", 64'(if_a.fault), 64'(m_fault));
    chk("sel_b", 64'(if_b.sel), 64'(m_sel));
    chk("valid_b", 64'(if_b.sel_valid), 64'(m_valid));
    chk("count_b", 64'(if_b.conflict_count), 64'(m_cnt2));
    chk("fault_b", 64'(if_b.fault), 64'(m_fault));
`ifdef BUS_ENC_ONEHOT_OUT_EN
    chk("onehot_a", 64'(if_a.sel_onehot), 64'(oh));
    chk("onehot_b", 64'(if_b.sel_onehot), 64'(oh));
`else
    if (oh != oh) chk("onehot_model", 64'(oh), 64'(oh));
`endif
  endtask
  task automatic step(input logic [31:0] r, input bit e = 1'b0, input bit c = 1'b0);
    if_a.out_req = r; if_b.out_req = r;
    if_a.err_clr = e; if_b.err_clr = e;
    clr = c;
    @(posedge clk);
    model(r, e, c);
    #1;
    check_all();
  endtask
  initial begin
    logic [31:0] r, prev;
    int k;
    if_a.out_req = '0; if_b.out_req = '0;
    if_a.err_clr = 1'b0; if_b.err_clr = 1'b0;
    step($urandom, 1'b0, 1'b1);
    step($urandom, 1'b1, 1'b1);
    step(32'h0);
    step(32'h0010_0000);
    chk("pc_sel_const", 64'(if_a.sel), 64'd20);
    step(32'h0);
    step(32'h0000_0012);
    chk("prio_sel_const", 64'(if_a.sel), 64'd1);
    step(32'h4);
    step(32'h0, 1'b1);
    repeat (6) step(32'h3);
    chk("fault_count_const", 64'(if_a.conflict_count), 64'd6);
    step(32'h8, 1'b1);
    step(32'h8);
    step(32'h0, 1'b1);
    repeat (5) begin
      step(32'h3);
      step(32'h0);
    end
    chk("sat_count_const", 64'(if_b.conflict_count), 64'd3);
    step(32'h5, 1'b1);
    step(32'h8000_0000);
    chk("msb_sel_const", 64'(if_a.sel), 64'd31);
    repeat (4) step(32'hC000_0000);
    step(32'h0, 1'b0, 1'b1);
    prev = 32'h3;
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3) r = 32'h0;
      else if (k < 6) r = 32'd1 << $urandom_range(0, 31);
      else if (k < 8 && $countones(prev) > 1) r = prev;
      else begin
        r = $urandom;
        if ($countones(r) < 2) r = r | (32'd3 << $urandom_range(0, 30));
      end
      prev = r;
      step(r, $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
